game_matrix_anim: RTL and testbench
===================================

// Module: game_matrix_anim
// PURPOSE
//  Parametrised game-board renderer: draws one cursor cell on a GRID_W x GRID_H board of CELLxCELL-pixel cells
//  into a flat 2-bit/pixel frame buffer, and plays a radius-R expanding blast animation on request.
//  Sits between game FSM (pos/color/start) and LED matrix scan driver (matrix_data). Successor of fixed 4x4 renderer.
// PARAMETERS
//  GRID_W   4          board columns (cells)
//  GRID_H   4          board rows (cells)
//  CELL     2          pixels per cell side
//  RADIUS   1          blast radius in cells, >=1
//  DIV      5_000_000  clk cycles per animation frame
//  Derived: PIX_W=GRID_W*CELL, PIX_H=GRID_H*CELL, MW=2*PIX_W*PIX_H, CW=$clog2(GRID_W), RW=$clog2(GRID_H)
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          async active-low reset
//  en           in   1          display enable; 0 blanks output, FSM keeps running
//  pos_row      in   RW         cursor cell row (0 = top)
//  pos_col      in   CW         cursor cell column (0 = left)
//  color        in   2          cursor/blast colour
//  boom_start   in   1          1-cycle pulse: start blast at current pos/color
//  boom_busy    out  1          high from cycle after accepted start until done pulse
//  boom_done    out  1          1-cycle pulse at end of last frame
//  matrix_data  out  MW         frame buffer; pixel p=y*PIX_W+x, bit 2p=colour[1], bit 2p+1=colour[0]
// BEHAVIOUR
//  - Clock clk, reset rst_n: asynchronous, active-low. Reset: FSM=IDLE, frame=0, divider=0, boom_busy=0, boom_done=0, matrix_data=0.
//  - FSM: IDLE -> (boom_start) ANIM -> (last frame tick) DONE -> IDLE (DONE lasts exactly 1 cycle, boom_done=1).
//  - IDLE: draws cursor cell (all CELL*CELL pixels) at live pos_row/pos_col with live color.
//  - Start accepted only in IDLE; pos/color latched at accept; boom_start in ANIM/DONE ignored.
//  - Divider cleared on accept; frame f lasts exactly DIV cycles; frames f=0..RADIUS+1.
//  - Frame f lights every cell at distance d with max(f-1,0) <= d <= min(f,RADIUS) from latched centre;
//    R=1: f0 centre, f1 centre+ring1, f2 ring1 only.
//  - Distance: Manhattan |dr|+|dc| (4-connected). Cells off board are clipped, never wrapped.
//  - Output registered: matrix_data reflects state/inputs with 1-cycle latency; en=0 forces 0 on next edge.
//  - Reset mid-animation: immediate IDLE, no done pulse; blank until first post-reset edge.
//  - Out-of-range pos (non-power-of-2 grid): nothing drawn.
// CONFIGURATION
//  GAME_MATRIX_DIAG_EN defined: distance is Chebyshev max(|dr|,|dc|) (8-connected, square rings incl. diagonals).
//  Undefined: Manhattan distance as above. Frame count and timing identical either way.
// STRUCTURE
//  game_matrix_pkg: FSM state encoding (IDLE/ANIM/DONE), pixel-index function, cell-distance function
//  (selected by GAME_MATRIX_DIAG_EN), derived width constants.
//  Sub-module game_frame_tick: DIV-cycle counter with sync clear, 1-cycle tick out; replaces free-running divider.
//  Top: FSM + frame counter + generate loop over cells computing lit mask -> pixel expansion -> output register.
// TESTING (defaults, DIV=4)
//  1 reset: rst_n=0 mid-run -> matrix_data=0, busy=0, done=0 asynchronously.
//  2 IDLE cursor row1 col2 color=2'b10 -> bits 2p=1,2p+1=0 for p in {20,21,28,29}; all other bits 0.
//  3 start at row0 col0 color=2'b11 -> f0 centre 4px; f1 adds (0,1),(1,0), no wrap; f2 ring only;
//    done pulse 12 cycles after accept; busy 12 cycles.
//  4 start at row3 col3, pos changed to row0 during ANIM -> blast stays at (3,3); second boom_start ignored.
//  5 en=0 during ANIM -> output 0, done still at cycle 12; en=1 restores current frame next cycle.
//  6 with GAME_MATRIX_DIAG_EN, centre (1,1), f2 -> 8 cells lit incl. (0,0),(2,2); centre dark.

Source files
------------

// File: rtl/game_matrix_pkg.sv
// Shared types and helpers for the game board renderer: FSM encoding, pixel
// indexing and cell distance (Chebyshev when GAME_MATRIX_DIAG_EN is defined, else Manhattan).
package game_matrix_pkg;

   localparam int COLOR_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ANIM = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Widths never drop to zero so single-row/column boards still elaborate.
   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

   function automatic int pix_index(input int x, input int y, input int pix_w);
      return y * pix_w + x;
   endfunction

   function automatic int abs_i(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int cell_dist(input int dr, input int dc);
`ifdef GAME_MATRIX_DIAG_EN
      return (abs_i(dr) > abs_i(dc)) ? abs_i(dr) : abs_i(dc);
`else
      return abs_i(dr) + abs_i(dc);
`endif
   endfunction

   // Frame f lights the band of rings from max(f-1,0) out to min(f,radius).
   function automatic logic ring_hit(input int d, input int f, input int radius);
      int lo;
      int hi;
      lo = (f > 0) ? f - 1 : 0;
      hi = (f < radius) ? f : radius;
      return (d >= lo) && (d <= hi);
   endfunction

endpackage

// File: rtl/game_frame_tick.sv
// Animation frame divider: counts DIV cycles while run is high, pulses tick on
// the last cycle of each frame; clr restarts the frame synchronously.
module game_frame_tick
   import game_matrix_pkg::*;
#(
   parameter int DIV = 5_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic run,
   output logic tick
);

   localparam int             DW      = clog2_min1(DIV);
   localparam logic [DW-1:0]  CNT_TOP = DW'(DIV - 1);

   logic [DW-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (run) begin
         count_reg <= (count_reg == CNT_TOP) ? '0 : count_reg + 1'b1;
      end
   end

   assign tick = run && (count_reg == CNT_TOP);

endmodule

// File: rtl/game_matrix_anim.sv
// Game board renderer: cursor cell in IDLE, expanding blast rings on boom_start.
// Define GAME_MATRIX_DIAG_EN for square (8-connected) blast rings.
module game_matrix_anim
   import game_matrix_pkg::*;
#(
   parameter  int GRID_W = 4,
   parameter  int GRID_H = 4,
   parameter  int CELL   = 2,
   parameter  int RADIUS = 1,
   parameter  int DIV    = 5_000_000,
   localparam int PIX_W  = GRID_W * CELL,
   localparam int PIX_H  = GRID_H * CELL,
   localparam int MW     = 2 * PIX_W * PIX_H,
   localparam int CW     = clog2_min1(GRID_W),
   localparam int RW     = clog2_min1(GRID_H)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [RW-1:0] pos_row,
   input  logic [CW-1:0] pos_col,
   input  logic [1:0]    color,
   input  logic          boom_start,
   output logic          boom_busy,
   output logic          boom_done,
   output logic [MW-1:0] matrix_data
);

   localparam int            CELLS      = GRID_W * GRID_H;
   localparam int            FW         = clog2_min1(RADIUS + 2);
   localparam logic [FW-1:0] LAST_FRAME = FW'(RADIUS + 1);

   state_t               state_reg;
   logic [FW-1:0]        frame_reg;
   logic [RW-1:0]        row_reg;
   logic [CW-1:0]        col_reg;
   logic [COLOR_W-1:0]   color_reg;
   logic                 busy_reg;
   logic                 done_reg;
   logic [MW-1:0]        matrix_reg;

   logic                 accept;
   logic                 anim_run;
   logic                 frame_tick;
   logic [CELLS-1:0]     cell_on;
   logic [COLOR_W-1:0]   draw_color;
   logic [MW-1:0]        matrix_next;

   assign accept   = (state_reg == ST_IDLE) && boom_start;
   assign anim_run = (state_reg == ST_ANIM);

   game_frame_tick #(
      .DIV (DIV)
   ) u_frame_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .run   (anim_run),
      .tick  (frame_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         frame_reg <= '0;
         row_reg   <= '0;
         col_reg   <= '0;
         color_reg <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (boom_start) begin
                  state_reg <= ST_ANIM;
                  frame_reg <= '0;
                  row_reg   <= pos_row;
                  col_reg   <= pos_col;
                  color_reg <= color;
                  busy_reg  <= 1'b1;
               end
            end
            ST_ANIM: begin
               if (frame_tick) begin
                  if (frame_reg == LAST_FRAME) begin
                     state_reg <= ST_DONE;
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                  end else begin
                     frame_reg <= frame_reg + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state_reg <= ST_IDLE;
               frame_reg <= '0;
               done_reg  <= 1'b0;
            end
            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign draw_color = anim_run ? color_reg : color;

   genvar gi, gj;
   generate
      for (gi = 0; gi < CELLS; gi++) begin : g_cell
         localparam int CR = gi / GRID_W;
         localparam int CC = gi % GRID_W;
         logic cursor_hit;
         logic blast_hit;
         // Out-of-range positions simply never match any cell.
         assign cursor_hit = (int'(pos_row) == CR) && (int'(pos_col) == CC);
         assign blast_hit  = ring_hit(cell_dist(CR - int'(row_reg), CC - int'(col_reg)),
                                      int'(frame_reg), RADIUS);
         assign cell_on[gi] = ((state_reg == ST_IDLE) && cursor_hit) ||
                              (anim_run && blast_hit);
      end

      for (gi = 0; gi < PIX_H; gi++) begin : g_pix_row
         for (gj = 0; gj < PIX_W; gj++) begin : g_pix_col
            localparam int P  = pix_index(gj, gi, PIX_W);
            localparam int CI = (gi / CELL) * GRID_W + (gj / CELL);
            assign matrix_next[2*P]   = cell_on[CI] & draw_color[1];
            assign matrix_next[2*P+1] = cell_on[CI] & draw_color[0];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         matrix_reg <= '0;
      end else begin
         matrix_reg <= en ? matrix_next : '0;
      end
   end

   assign boom_busy   = busy_reg;
   assign boom_done   = done_reg;
   assign matrix_data = matrix_reg;

endmodule

// File: tb/tb_game_matrix_anim.sv
// Self-checking bench for game_matrix_anim (DIV=4) against a pixel-level reference
// model; honours GAME_MATRIX_DIAG_EN for the distance rule.
module tb_game_matrix_anim;

   localparam int GRID_W = 4;
   localparam int GRID_H = 4;
   localparam int CELL   = 2;
   localparam int RADIUS = 1;
   localparam int DIV    = 4;
   localparam int PIX_W  = GRID_W * CELL;
   localparam int PIX_H  = GRID_H * CELL;
   localparam int MW     = 2 * PIX_W * PIX_H;
   localparam int CW     = 2;
   localparam int RW     = 2;
   localparam int TOTAL  = (RADIUS + 2) * DIV;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [RW-1:0] pos_row;
   logic [CW-1:0] pos_col;
   logic [1:0]    color;
   logic          boom_start;
   logic          boom_busy;
   logic          boom_done;
   logic [MW-1:0] matrix_data;

   int errors = 0;
   int checks = 0;

   game_matrix_anim #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H),
      .CELL   (CELL),
      .RADIUS (RADIUS),
      .DIV    (DIV)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .pos_row     (pos_row),
      .pos_col     (pos_col),
      .color       (color),
      .boom_start  (boom_start),
      .boom_busy   (boom_busy),
      .boom_done   (boom_done),
      .matrix_data (matrix_data)
   );

   always #5 clk = ~clk;

   function automatic int model_dist(input int dr, input int dc);
      int ar;
      int ac;
      ar = (dr < 0) ? -dr : dr;
      ac = (dc < 0) ? -dc : dc;
`ifdef GAME_MATRIX_DIAG_EN
      return (ar > ac) ? ar : ac;
`else
      return ar + ac;
`endif
   endfunction

   // f < 0 renders the idle cursor; otherwise blast frame f.
   function automatic logic [MW-1:0] model_img(input int cr, input int cc,
                                               input logic [1:0] col, input int f);
      logic [MW-1:0] img;
      img = '0;
      for (int y = 0; y < PIX_H; y++) begin
         for (int x = 0; x < PIX_W; x++) begin
            int  d;
            int  p;
            bit  on;
            if (f < 0) begin
               on = (y / CELL == cr) && (x / CELL == cc);
            end else begin
               d  = model_dist(y / CELL - cr, x / CELL - cc);
               on = (d >= ((f > 0) ? f - 1 : 0)) && (d <= ((f < RADIUS) ? f : RADIUS));
            end
            p = y * PIX_W + x;
            if (on) begin
               img[2*p]   = col[1];
               img[2*p+1] = col[0];
            end
         end
      end
      return img;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (matrix_data !== '0) begin
         errors++;
         $display("FAIL reset_data got=%h exp=0", matrix_data);
      end
      checks++;
      if (boom_busy !== 1'b0 || boom_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got busy=%b done=%b exp 0/0", boom_busy, boom_done);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_cursor_fixed();
      logic [MW-1:0] exp;
      int            px [4];
      px = '{20, 21, 28, 29};
      exp = '0;
      for (int i = 0; i < 4; i++) exp[2*px[i]] = 1'b1;
      pos_row = 2'd1;
      pos_col = 2'd2;
      color   = 2'b10;
      step();
      checks++;
      if (matrix_data !== exp) begin
         errors++;
         $display("FAIL cursor_fixed got=%h exp=%h", matrix_data, exp);
      end
   endtask

   task automatic test_cursor_random();
      for (int i = 0; i < 6; i++) begin
         logic [MW-1:0] exp;
         int            r;
         int            c;
         logic [1:0]    col;
         r   = int'($urandom_range(0, GRID_H - 1));
         c   = int'($urandom_range(0, GRID_W - 1));
         col = 2'($urandom_range(1, 3));
         pos_row = RW'(r);
         pos_col = CW'(c);
         color   = col;
         step();
         exp = model_img(r, c, col, -1);
         checks++;
         if (matrix_data !== exp || boom_busy !== 1'b0) begin
            errors++;
            $display("FAIL cursor_rand r=%0d c=%0d got=%h busy=%b exp=%h busy=0",
                     r, c, matrix_data, boom_busy, exp);
         end
      end
   endtask

   task automatic test_blast(input int cr, input int cc, input logic [1:0] col);
      logic [MW-1:0] exp;
      pos_row    = RW'(cr);
      pos_col    = CW'(cc);
      color      = col;
      boom_start = 1'b1;
      step();
      boom_start = 1'b0;
      checks++;
      if (boom_busy !== 1'b1 || boom_done !== 1'b0) begin
         errors++;
         $display("FAIL blast_accept got busy=%b done=%b exp 1/0", boom_busy, boom_done);
      end
      for (int k = 1; k <= TOTAL + 1; k++) begin
         step();
         checks++;
         if (boom_busy !== (k < TOTAL) || boom_done !== (k == TOTAL)) begin
            errors++;
            $display("FAIL blast_flags k=%0d got busy=%b done=%b exp busy=%b done=%b",
                     k, boom_busy, boom_done, k < TOTAL, k == TOTAL);
         end
         if (k <= TOTAL) begin
            exp = model_img(cr, cc, col, (k - 1) / DIV);
            checks++;
            if (matrix_data !== exp) begin
               errors++;
               $display("FAIL blast_frame (%0d,%0d) k=%0d got=%h exp=%h",
                        cr, cc, k, matrix_data, exp);
            end
         end
         if (cr == 0 && cc == 0 && col == 2'b11 && k == DIV + 2) begin
            checks++;
            if ($countones(matrix_data) != 3 * CELL * CELL * 2) begin
               errors++;
               $display("FAIL corner_clip got=%0d bits exp=%0d",
                        $countones(matrix_data), 3 * CELL * CELL * 2);
            end
         end
      end
      step();
      exp = model_img(cr, cc, col, -1);
      checks++;
      if (matrix_data !== exp) begin
         errors++;
         $display("FAIL blast_back_idle got=%h exp=%h", matrix_data, exp);
      end
   endtask

   task automatic test_latch();
      logic [MW-1:0] exp;
      logic [1:0]    col;
      col        = 2'($urandom_range(1, 3));
      pos_row    = 2'd3;
      pos_col    = 2'd3;
      color      = col;
      boom_start = 1'b1;
      step();
      boom_start = 1'b0;
      for (int k = 1; k <= TOTAL + 1; k++) begin
         if (k == 3) begin
            pos_row = 2'd0;
            pos_col = 2'd1;
            color   = ~col;
         end
         boom_start = (k == 5);
         step();
         checks++;
         if (boom_busy !== (k < TOTAL) || boom_done !== (k == TOTAL)) begin
            errors++;
            $display("FAIL latch_flags k=%0d got busy=%b done=%b", k, boom_busy, boom_done);
         end
         if (k <= TOTAL) begin
            exp = model_img(3, 3, col, (k - 1) / DIV);
            checks++;
            if (matrix_data !== exp) begin
               errors++;
               $display("FAIL latch_frame k=%0d got=%h exp=%h", k, matrix_data, exp);
            end
         end
      end
      boom_start = 1'b0;
      step();
      exp = model_img(0, 1, ~col, -1);
      checks++;
      if (matrix_data !== exp) begin
         errors++;
         $display("FAIL latch_idle got=%h exp=%h", matrix_data, exp);
      end
   endtask

   task automatic test_enable();
      logic [MW-1:0] exp;
      logic [1:0]    col;
      logic          en_now;
      int            cr;
      int            cc;
      cr  = int'($urandom_range(0, GRID_H - 1));
      cc  = int'($urandom_range(0, GRID_W - 1));
      col = 2'($urandom_range(1, 3));
      pos_row    = RW'(cr);
      pos_col    = CW'(cc);
      color      = col;
      boom_start = 1'b1;
      step();
      boom_start = 1'b0;
      for (int k = 1; k <= TOTAL; k++) begin
         en     = !(k >= 4 && k <= 7);
         en_now = en;
         step();
         exp = en_now ? model_img(cr, cc, col, (k - 1) / DIV) : '0;
         checks++;
         if (matrix_data !== exp || boom_done !== (k == TOTAL)) begin
            errors++;
            $display("FAIL enable k=%0d en=%b got=%h done=%b exp=%h done=%b",
                     k, en_now, matrix_data, boom_done, exp, k == TOTAL);
         end
      end
      en = 1'b1;
      repeat (2) step();
   endtask

   task automatic test_reset_mid();
      logic [MW-1:0] exp;
      pos_row    = 2'd2;
      pos_col    = 2'd1;
      color      = 2'b01;
      boom_start = 1'b1;
      step();
      boom_start = 1'b0;
      repeat (5) step();
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (matrix_data !== '0 || boom_busy !== 1'b0 || boom_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid got data=%h busy=%b done=%b exp 0", matrix_data, boom_busy, boom_done);
      end
      step();
      checks++;
      if (matrix_data !== '0) begin
         errors++;
         $display("FAIL reset_hold got=%h exp=0", matrix_data);
      end
      rst_n = 1'b1;
      exp = model_img(2, 1, 2'b01, -1);
      for (int k = 1; k <= TOTAL + 2; k++) begin
         step();
         checks++;
         if (matrix_data !== exp || boom_busy !== 1'b0 || boom_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_after k=%0d got data=%h busy=%b done=%b exp data=%h 0/0",
                     k, matrix_data, boom_busy, boom_done, exp);
         end
      end
   endtask

   task automatic test_ring_shape();
      int  exp_cells;
      bit  diag;
`ifdef GAME_MATRIX_DIAG_EN
      diag = 1'b1;
`else
      diag = 1'b0;
`endif
      exp_cells  = diag ? 8 : 4;
      pos_row    = 2'd1;
      pos_col    = 2'd1;
      color      = 2'b01;
      boom_start = 1'b1;
      step();
      boom_start = 1'b0;
      for (int k = 1; k <= TOTAL + 1; k++) begin
         step();
         if (k == 2 * DIV + 2) begin
            checks++;
            if ($countones(matrix_data) != exp_cells * CELL * CELL) begin
               errors++;
               $display("FAIL ring_count got=%0d exp=%0d", $countones(matrix_data),
                        exp_cells * CELL * CELL);
            end
            checks++;
            if (matrix_data[1] !== diag || matrix_data[2*36+1] !== diag ||
                matrix_data[2*18+1] !== 1'b0) begin
               errors++;
               $display("FAIL ring_pixels got (0,0)=%b (2,2)=%b ctr=%b exp %b %b 0",
                        matrix_data[1], matrix_data[2*36+1], matrix_data[2*18+1], diag, diag);
            end
         end
         if (k == TOTAL) begin
            checks++;
            if (boom_done !== 1'b1) begin
               errors++;
               $display("FAIL ring_done got=%b exp=1", boom_done);
            end
         end
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      en         = 1'b1;
      pos_row    = '0;
      pos_col    = '0;
      color      = '0;
      boom_start = 1'b0;
      test_reset();
      test_cursor_fixed();
      test_cursor_random();
      test_blast(0, 0, 2'b11);
      for (int i = 0; i < 3; i++) begin
         test_blast(int'($urandom_range(0, GRID_H - 1)), int'($urandom_range(0, GRID_W - 1)),
                    2'($urandom_range(1, 3)));
      end
      test_latch();
      test_enable();
      test_ring_shape();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
